sample_ram_write_ctrl: RTL

//  Capture write controller that sits directly upstream of the banked sample RAM.
//  - Takes the 64-bit ADC sample stream and drives the RAM's A-port: A_ADDR, block select, A_DIN, A_WEN.
//  - Runs a circular pre-trigger / post-trigger acquisition across NUM_BLOCKS RAM blocks.
//  - Reports where the captured record starts and where the trigger sample sits, for the readout logic.

---
 rtl/sample_ram_pkg.sv | 41 ++++
 rtl/sample_ram_addr_gen.sv | 44 ++++
 rtl/sample_ram_write_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sample_ram_pkg.sv
// Shared types and sizing helpers for the sample RAM capture write controller.
package sample_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } state_t;

  typedef struct packed {
    int blk;
    int word;
  } ptr_split_t;

  function automatic int capacity_f(int num_blocks, int depth);
    return num_blocks * depth;
  endfunction

  function automatic int ptr_w_f(int num_blocks, int depth);
    return (num_blocks * depth > 1) ? $clog2(num_blocks * depth) : 1;
  endfunction

  function automatic int word_w_f(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Linear pointer <-> (block, word) conversions.
  function automatic ptr_split_t ptr_split(int lin, int depth);
    ptr_split_t r;
    r.blk  = lin / depth;
    r.word = lin % depth;
    return r;
  endfunction

  function automatic int ptr_join(int blk, int word, int depth);
    return blk * depth + word;
  endfunction

endpackage

// File: rtl/sample_ram_addr_gen.sv
// Block/word write pointer for the banked sample RAM; wraps across blocks and
// flags the first wrap of the last block back to block 0.
module sample_ram_addr_gen
  import sample_ram_pkg::*;
#(
  parameter int NUM_BLOCKS  = 3,
  parameter int BLOCK_DEPTH = 1024,
  parameter int BLK_SEL_W   = 4,
  localparam int WORD_W     = word_w_f(BLOCK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [BLK_SEL_W-1:0] blk,
  output logic [WORD_W-1:0]    word,
  output logic                 wrapped
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk     <= '0;
      word    <= '0;
      wrapped <= 1'b0;
    end else if (clear) begin
      blk     <= '0;
      word    <= '0;
      wrapped <= 1'b0;
    end else if (inc) begin
      if (word == WORD_W'(BLOCK_DEPTH - 1)) begin
        word <= '0;
        if (blk == BLK_SEL_W'(NUM_BLOCKS - 1)) begin
          blk     <= '0;
          wrapped <= 1'b1;
        end else begin
          blk <= blk + 1'b1;
        end
      end else begin
        word <= word + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_ram_write_ctrl.sv
// Pre/post-trigger circular capture controller driving the sample RAM A-port.
// Optional macro SAMPLE_RAM_WR_SW_TRIG_EN adds a software trigger input.
module sample_ram_write_ctrl
  import sample_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int BLK_SEL_W   = 4,
  parameter int NUM_BLOCKS  = 3,
  parameter int BLOCK_DEPTH = 1024,
  localparam int CAPACITY   = capacity_f(NUM_BLOCKS, BLOCK_DEPTH),
  localparam int PTR_W      = ptr_w_f(NUM_BLOCKS, BLOCK_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Arm,
  input  logic                  Abort,
  input  logic                  Trigger,
`ifdef SAMPLE_RAM_WR_SW_TRIG_EN
  input  logic                  SW_Trigger,
`endif
  input  logic [PTR_W-1:0]      Pretrig_Len,
  input  logic [PTR_W-1:0]      Posttrig_Len,
  input  logic [DATA_WIDTH-1:0] Sample_Data,
  input  logic                  Sample_Valid,
  output logic [ADDR_WIDTH-1:0] A_ADDR,
  output logic [BLK_SEL_W-1:0]  A_Block_Address_vector,
  output logic [DATA_WIDTH-1:0] A_DIN,
  output logic                  A_WEN,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Wrapped,
  output logic [PTR_W-1:0]      Trig_Pointer,
  output logic [PTR_W-1:0]      Start_Pointer
);

  localparam int WORD_W = word_w_f(BLOCK_DEPTH);
  localparam logic [PTR_W:0] CAP_X = (PTR_W + 1)'(CAPACITY);

  state_t               state, state_nx;
  logic [BLK_SEL_W-1:0] blk;
  logic [WORD_W-1:0]    word;
  logic [PTR_W-1:0]     cur_ptr, pre_arm, post_arm;
  logic [PTR_W-1:0]     pre_eff, post_eff, pre_cnt, post_cnt;
  logic [PTR_W:0]       back_sum, fwd_sum;
  logic                 capturing, wr, trig, arm_go, fits;

  sample_ram_addr_gen #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .BLOCK_DEPTH(BLOCK_DEPTH),
    .BLK_SEL_W  (BLK_SEL_W)
  ) u_addr_gen (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clear  (arm_go),
    .inc    (wr),
    .blk    (blk),
    .word   (word),
    .wrapped(Wrapped)
  );

  assign cur_ptr   = PTR_W'(ptr_join(int'(blk), int'(word), BLOCK_DEPTH));
  assign pre_arm   = (Pretrig_Len > PTR_W'(CAPACITY - 1)) ? PTR_W'(CAPACITY - 1) : Pretrig_Len;
  assign post_arm  = (Posttrig_Len == '0) ? PTR_W'(1) : Posttrig_Len;
  assign capturing = (state == PRETRIG) || (state == ARMED) || (state == POSTTRIG);
  assign wr        = capturing && Sample_Valid && !Abort;
  assign arm_go    = Arm && !Abort && ((state == IDLE) || (state == DONE));
  assign Busy      = capturing;
  assign Done      = (state == DONE);

`ifdef SAMPLE_RAM_WR_SW_TRIG_EN
  // A software trigger without a sample marks the address the next write will use.
  assign trig = !Abort && (((state == ARMED) && Trigger && Sample_Valid) ||
                           (((state == ARMED) || (state == PRETRIG)) && SW_Trigger));
`else
  assign trig = !Abort && (state == ARMED) && Trigger && Sample_Valid;
`endif

  // When the record is longer than the RAM, the oldest survivor is the slot after the last write.
  assign back_sum = ({1'b0, cur_ptr} + CAP_X - {1'b0, pre_eff}) % CAP_X;
  assign fwd_sum  = ({1'b0, cur_ptr} + {1'b0, post_eff}) % CAP_X;
  assign fits     = ({1'b0, pre_eff} + {1'b0, post_eff}) <= CAP_X;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (Abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (Arm) state_nx = (pre_arm == '0) ? ARMED : PRETRIG;
        PRETRIG: begin
          if (trig)                                     state_nx = (wr && post_eff == PTR_W'(1)) ? DONE : POSTTRIG;
          else if (wr && (pre_cnt + 1'b1) == pre_eff)   state_nx = ARMED;
        end
        ARMED:    if (trig) state_nx = (wr && post_eff == PTR_W'(1)) ? DONE : POSTTRIG;
        POSTTRIG: if (wr && (post_cnt + 1'b1) == post_eff) state_nx = DONE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      A_WEN                  <= 1'b0;
      A_ADDR                 <= '0;
      A_Block_Address_vector <= '0;
      A_DIN                  <= '0;
      pre_eff                <= '0;
      post_eff               <= PTR_W'(1);
      pre_cnt                <= '0;
      post_cnt               <= '0;
      Trig_Pointer           <= '0;
      Start_Pointer          <= '0;
    end else begin
      A_WEN <= wr;
      if (wr) begin
        A_ADDR                 <= ADDR_WIDTH'(word);
        A_Block_Address_vector <= blk;
        A_DIN                  <= Sample_Data;
      end
      if (arm_go) begin
        pre_eff  <= pre_arm;
        post_eff <= post_arm;
        pre_cnt  <= '0;
      end else if (wr && state == PRETRIG) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (trig) begin
        Trig_Pointer  <= cur_ptr;
        Start_Pointer <= fits ? back_sum[PTR_W-1:0] : fwd_sum[PTR_W-1:0];
        post_cnt      <= wr ? PTR_W'(1) : '0;
      end else if (wr && state == POSTTRIG) begin
        post_cnt <= post_cnt + 1'b1;
      end
    end
  end

endmodule
